// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
// Received words sit in a single holding register behind a valid/ready handshake.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig_rx,
  output logic [DATA_WIDTH-1:0] data_rx,
  output logic                  valid_rx,
  input  logic                  ready_rx,
  output logic                  err_frame,
  output logic                  err_overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int DCNT_W           = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  FULL_RELOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [DCNT_W-1:0] LAST_BIT    = DCNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic                  sync_meta_r, sync_rx_r;
  logic [CNT_W-1:0]      clk_cnt_r, clk_cnt_s;
  logic [DCNT_W-1:0]     data_cnt_r, data_cnt_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [DATA_WIDTH-1:0] data_r, data_s;
  logic                  valid_r, valid_s;
  logic                  err_frame_r, err_frame_s;
  logic                  err_overrun_r, err_overrun_s;
  logic                  cnt_zero_s;

  assign data_rx     = data_r;
  assign valid_rx    = valid_r;
  assign err_frame   = err_frame_r;
  assign err_overrun = err_overrun_r;
  assign cnt_zero_s  = (clk_cnt_r == {CNT_W{1'b0}});

  // Next-state, datapath and handshake decisions.
  always_comb begin
    state_s       = state_r;
    clk_cnt_s     = clk_cnt_r;
    data_cnt_s    = data_cnt_r;
    shift_s       = shift_r;
    data_s        = data_r;
    valid_s       = (valid_r && ready_rx) ? 1'b0 : valid_r;
    err_frame_s   = 1'b0;
    err_overrun_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!sync_rx_r) begin
          clk_cnt_s = HALF_RELOAD;
          state_s   = ST_START;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_START: begin
        if (!cnt_zero_s) begin
          clk_cnt_s = clk_cnt_r - CNT_W'(1);
        end else if (!sync_rx_r) begin
          clk_cnt_s  = FULL_RELOAD;
          data_cnt_s = {DCNT_W{1'b0}};
          state_s    = ST_DATA;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!cnt_zero_s) begin
          clk_cnt_s = clk_cnt_r - CNT_W'(1);
        end else begin
          // Right shift with new bit at the MSB leaves the first bit in bit 0.
          shift_s   = (shift_r >> 1) | (DATA_WIDTH'(sync_rx_r) << (DATA_WIDTH - 1));
          clk_cnt_s = FULL_RELOAD;
          if (data_cnt_r == LAST_BIT) begin
            state_s    = ST_STOP;
          end else begin
            data_cnt_s = data_cnt_r + DCNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (!cnt_zero_s) begin
          clk_cnt_s = clk_cnt_r - CNT_W'(1);
        end else if (sync_rx_r) begin
          // Back to IDLE at mid-stop so a back-to-back start edge is caught.
          state_s = ST_IDLE;
          if (!valid_r || ready_rx) begin
            data_s  = shift_r;
            valid_s = 1'b1;
          end else begin
            err_overrun_s = 1'b1;
          end
        end else begin
          err_frame_s = 1'b1;
          state_s     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (sync_rx_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_meta_r   <= 1'b1;
      sync_rx_r     <= 1'b1;
      state_r       <= ST_IDLE;
      clk_cnt_r     <= {CNT_W{1'b0}};
      data_cnt_r    <= {DCNT_W{1'b0}};
      shift_r       <= {DATA_WIDTH{1'b0}};
      data_r        <= {DATA_WIDTH{1'b0}};
      valid_r       <= 1'b0;
      err_frame_r   <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      sync_meta_r   <= sig_rx;
      sync_rx_r     <= sync_meta_r;
      state_r       <= state_s;
      clk_cnt_r     <= clk_cnt_s;
      data_cnt_r    <= data_cnt_s;
      shift_r       <= shift_s;
      data_r        <= data_s;
      valid_r       <= valid_s;
      err_frame_r   <= err_frame_s;
      err_overrun_r <= err_overrun_s;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// with a word-level scoreboard and a decoupled monitor.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DW       = 8;
  localparam int PW       = CLK_FREQ / BAUD;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sig_rx = 1'b1;
  logic          ready_rx = 1'b1;
  logic [DW-1:0] data_rx;
  logic          valid_rx;
  logic          err_frame;
  logic          err_overrun;

  uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk), .rstn(rstn), .sig_rx(sig_rx),
    .data_rx(data_rx), .valid_rx(valid_rx), .ready_rx(ready_rx),
    .err_frame(err_frame), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [7:0] exp_q[$];
  int frame_exp = 0, ovr_exp = 0, frame_seen = 0, ovr_seen = 0, vcyc = 0;
  int lat_start = 0;
  bit lat_armed = 1'b0, lat_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: decides a frame's fate from framing and holding-register occupancy.
  task automatic model_frame(input logic [7:0] d, input logic stop_val);
    if (!stop_val) frame_exp++;
    else if (!ready_rx && exp_q.size() != 0) ovr_exp++;
    else exp_q.push_back(d);
  endtask

  task automatic hold(input logic v, input int n);
    sig_rx = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    model_frame(d, stop_val);
    hold(1'b0, PW);
    for (int i = 0; i < DW; i++) hold(d[i], PW);
    hold(stop_val, PW);
  endtask

  // Monitor: pops the scoreboard on every transfer and tracks error pulses.
  initial begin
    logic       prev_valid, prev_ready;
    logic [7:0] prev_data;
    int         lat;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_valid = 1'b0;
      end else begin
        if (err_frame) frame_seen++;
        if (err_overrun) ovr_seen++;
        if (valid_rx) vcyc++;
        if (valid_rx && !prev_valid && lat_armed) begin
          lat = cyc - lat_start;
          lat_armed = 1'b0;
          lat_done = 1'b1;
          check("latency_window", {31'd0, (lat >= 95 && lat <= 99)}, 32'd1);
        end
        if (valid_rx && prev_valid && !prev_ready)
          check("data_stable", {24'd0, data_rx}, {24'd0, prev_data});
        if (valid_rx && ready_rx) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_word: got 0x%0h expected no word", data_rx);
          end else begin
            check("data_rx", {24'd0, data_rx}, {24'd0, exp_q.pop_front()});
          end
        end
        prev_valid = valid_rx; prev_ready = ready_rx; prev_data = data_rx;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    logic [7:0] d;
    int gap;
    logic [7:0] abort_d;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, valid_rx}, 32'd0);
    check("reset_data", {24'd0, data_rx}, 32'd0);
    check("reset_err_frame", {31'd0, err_frame}, 32'd0);
    check("reset_err_overrun", {31'd0, err_overrun}, 32'd0);
    rstn = 1'b1;
    hold(1'b1, 10);

    // Basic receive with latency and single-cycle valid.
    v0 = vcyc;
    lat_start = cyc; lat_armed = 1'b1; lat_done = 1'b0;
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 10);
    check("latency_seen", {31'd0, lat_done}, 32'd1);
    check("valid_one_cycle", vcyc - v0, 32'd1);
    check("t1_frame_errs", frame_seen, 32'd0);
    check("t1_overruns", ovr_seen, 32'd0);

    // Start glitch rejected.
    v0 = vcyc;
    hold(1'b0, 3);
    hold(1'b1, 15);
    check("glitch_no_valid", vcyc - v0, 32'd0);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 10);
    check("t2_drained", exp_q.size(), 32'd0);
    check("t2_frame_errs", frame_seen, frame_exp);

    // Framing error with held-low break.
    send_frame(8'h55, 1'b0);
    hold(1'b0, 50);
    hold(1'b1, 20);
    check("frame_err_pulses", frame_seen, frame_exp);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 10);
    check("t3_drained", exp_q.size(), 32'd0);
    check("t3_frame_errs", frame_seen, frame_exp);

    // Overrun while holding register full.
    ready_rx = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 10);
    check("ovr_valid_held", {31'd0, valid_rx}, 32'd1);
    check("ovr_data_held", {24'd0, data_rx}, 32'h11);
    check("overrun_pulses", ovr_seen, ovr_exp);
    ready_rx = 1'b1;
    @(posedge clk); #1;
    ready_rx = 1'b0;
    hold(1'b1, 3);
    check("valid_falls", {31'd0, valid_rx}, 32'd0);
    ready_rx = 1'b1;
    hold(1'b1, 10);
    check("t4_drained", exp_q.size(), 32'd0);

    // Back-to-back frames with one stop bit.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 10);
    check("t5_drained", exp_q.size(), 32'd0);
    check("t5_frame_errs", frame_seen, frame_exp);
    check("t5_overruns", ovr_seen, ovr_exp);

    // Random frames with random idle gaps (including none).
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 12);
      send_frame(d, 1'b1);
      if (gap != 0) hold(1'b1, gap);
    end
    hold(1'b1, 10);
    check("rand_drained", exp_q.size(), 32'd0);

    // Reset mid-frame with a word held, then a clean frame.
    ready_rx = 1'b0;
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 5);
    check("t6_word_held", {31'd0, valid_rx}, 32'd1);
    abort_d = 8'h5A;
    hold(1'b0, PW);
    for (int i = 0; i < 3; i++) hold(abort_d[i], PW);
    sig_rx = abort_d[3];
    repeat (4) @(posedge clk);
    #3;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("async_clear_valid", {31'd0, valid_rx}, 32'd0);
    check("async_clear_data", {24'd0, data_rx}, 32'd0);
    check("async_clear_errs", {30'd0, err_frame, err_overrun}, 32'd0);
    sig_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    ready_rx = 1'b1;
    v0 = vcyc;
    hold(1'b1, 20);
    check("no_stale_valid", vcyc - v0, 32'd0);
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 20);

    check("final_drained", exp_q.size(), 32'd0);
    check("final_frame_errs", frame_seen, frame_exp);
    check("final_overruns", ovr_seen, ovr_exp);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
